// File: rtl/ones_residue_pkg.sv
// Shared types and arithmetic helpers for the ones-residue detector.
package ones_residue_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Reference popcount over a word of up to 64 bits.
  function automatic int popcount(input logic [63:0] v, input int width);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      if (i < width) cnt += int'(v[i]);
    end
    return cnt;
  endfunction

  // (r + p) mod m, exact for any p; no single-subtract shortcut.
  function automatic int mod_add(input int r, input int p, input int m);
    return (r + p) % m;
  endfunction

  // a + b clamped to max_v.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] max_v);
    logic [63:0] s;
    s = a + b;
    return (s > max_v) ? max_v : s;
  endfunction

endpackage

// File: rtl/ones_popcount.sv
// Combinational ones counter for one input beat.
module ones_popcount #(
  parameter int DATA_W = 8,
  localparam int CNT_W = $clog2(DATA_W + 1)
) (
  input  logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  count
);

  // Sum of the individual data bits.
  always_comb begin
    count = '0;
    for (int i = 0; i < DATA_W; i++) begin
      count = count + CNT_W'(data[i]);
    end
  end

endmodule

// File: rtl/ones_residue_detector.sv
// Running ones-count residue detector with framing, per-frame results,
// saturating frame totals and a synchronous frame abort.
module ones_residue_detector
  import ones_residue_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int MOD    = 2,
  parameter int TARGET = 1,
  parameter int TOT_W  = 16,
  localparam int RES_W = ($clog2(MOD) > 1) ? $clog2(MOD) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic [RES_W-1:0]  residue,
  output logic              match,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_match,
  output logic [TOT_W-1:0]  frame_ones
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [63:0] SAT_MAX = (64'd1 << TOT_W) - 64'd1;

  if ((TARGET < 0) || (TARGET >= MOD)) begin : g_bad_target
    $error("ones_residue_detector: TARGET must satisfy 0 <= TARGET < MOD");
  end

  state_t             state_p1, state_d;
  logic [RES_W-1:0]   residue_p1, residue_d;
  logic [TOT_W-1:0]   total_p1, total_d;
  logic               vld_p1, vld_d;
  logic               fmatch_p1, fmatch_d;
  logic [TOT_W-1:0]   fones_p1, fones_d;

  logic [CNT_W-1:0]   pcnt_p0;
  logic [RES_W-1:0]   nxt_p0;
  logic [TOT_W-1:0]   tot_p0;

  ones_popcount #(.DATA_W(DATA_W)) u_popcount (
    .data  (in_data),
    .count (pcnt_p0)
  );

  assign nxt_p0 = RES_W'(mod_add(int'(residue_p1), int'(pcnt_p0), MOD));
  assign tot_p0 = TOT_W'(sat_add(64'(total_p1), 64'(pcnt_p0), SAT_MAX));

  // Stage p0 -> p1: next-state and register update decisions (clear > beat > hold).
  always_comb begin
    state_d   = state_p1;
    residue_d = residue_p1;
    total_d   = total_p1;
    vld_d     = 1'b0;
    fmatch_d  = fmatch_p1;
    fones_d   = fones_p1;
    if (clear) begin
      state_d   = IDLE;
      residue_d = '0;
      total_d   = '0;
    end else if (in_valid) begin
      if (in_last) begin
        state_d   = IDLE;
        residue_d = '0;
        total_d   = '0;
        vld_d     = 1'b1;
        fmatch_d  = (nxt_p0 == RES_W'(TARGET));
        fones_d   = tot_p0;
      end else begin
        state_d   = ACTIVE;
        residue_d = nxt_p0;
        total_d   = tot_p0;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_p1 <= IDLE;
    else          state_p1 <= state_d;
  end

  // Running residue/total and last-frame result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      residue_p1 <= '0;
      total_p1   <= '0;
      vld_p1     <= 1'b0;
      fmatch_p1  <= 1'b0;
      fones_p1   <= '0;
    end else begin
      residue_p1 <= residue_d;
      total_p1   <= total_d;
      vld_p1     <= vld_d;
      fmatch_p1  <= fmatch_d;
      fones_p1   <= fones_d;
    end
  end

  assign residue     = residue_p1;
  assign match       = (residue_p1 == RES_W'(TARGET));
  assign busy        = (state_p1 == ACTIVE);
  assign frame_done  = vld_p1;
  assign frame_match = fmatch_p1;
  assign frame_ones  = fones_p1;

endmodule

// File: tb/tb_ones_residue_detector.sv
// Bench for ones_residue_detector: three configurations share one stimulus stream.
module tb_ones_residue_detector;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic [7:0] data8 = 8'h00;

  // A: legacy W=1 MOD=2 T=1; B: W=8 MOD=3 T=0; C: W=8 MOD=5 T=2 TOT_W=4
  logic [0:0]  a_res; logic a_match, a_busy, a_done, a_fm; logic [15:0] a_fo;
  logic [1:0]  b_res; logic b_match, b_busy, b_done, b_fm; logic [15:0] b_fo;
  logic [2:0]  c_res; logic c_match, c_busy, c_done, c_fm; logic [3:0]  c_fo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ones_residue_detector #(.DATA_W(1), .MOD(2), .TARGET(1), .TOT_W(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid),
    .in_data(data8[0:0]), .in_last(in_last), .residue(a_res), .match(a_match),
    .busy(a_busy), .frame_done(a_done), .frame_match(a_fm), .frame_ones(a_fo));

  ones_residue_detector #(.DATA_W(8), .MOD(3), .TARGET(0), .TOT_W(16)) dut_b (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid),
    .in_data(data8), .in_last(in_last), .residue(b_res), .match(b_match),
    .busy(b_busy), .frame_done(b_done), .frame_match(b_fm), .frame_ones(b_fo));

  ones_residue_detector #(.DATA_W(8), .MOD(5), .TARGET(2), .TOT_W(4)) dut_c (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid),
    .in_data(data8), .in_last(in_last), .residue(c_res), .match(c_match),
    .busy(c_busy), .frame_done(c_done), .frame_match(c_fm), .frame_ones(c_fo));

  // Apply one cycle of stimulus; outputs are examined 1 time unit after the edge.
  task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic c);
    in_valid = v; data8 = d; in_last = l; clear = c;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; clear = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      int r, m, b, fd, fm, fo, em;
      r  = (i == 0) ? int'(a_res)   : (i == 1) ? int'(b_res)   : int'(c_res);
      m  = (i == 0) ? int'(a_match) : (i == 1) ? int'(b_match) : int'(c_match);
      b  = (i == 0) ? int'(a_busy)  : (i == 1) ? int'(b_busy)  : int'(c_busy);
      fd = (i == 0) ? int'(a_done)  : (i == 1) ? int'(b_done)  : int'(c_done);
      fm = (i == 0) ? int'(a_fm)    : (i == 1) ? int'(b_fm)    : int'(c_fm);
      fo = (i == 0) ? int'(a_fo)    : (i == 1) ? int'(b_fo)    : int'(c_fo);
      em = (i == 1) ? 1 : 0;
      checks++;
      if (r !== 0 || m !== em || b !== 0 || fd !== 0 || fm !== 0 || fo !== 0) begin
        errors++;
        $display("FAIL reset[%0d]: got res=%0d match=%0d busy=%0d done=%0d fm=%0d fo=%0d, want 0 %0d 0 0 0 0",
                 i, r, m, b, fd, fm, fo, em);
      end
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_legacy();
    logic [7:0] beats [4] = '{8'h01, 8'h00, 8'h01, 8'h01};
    logic       exp   [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, beats[i], 1'b0, 1'b0);
      checks++;
      if (a_match !== exp[i]) begin
        errors++;
        $display("FAIL legacy_match[%0d]: got %0b want %0b", i, a_match, exp[i]);
      end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_frame();
    logic [7:0] beats [3] = '{8'hFF, 8'h07, 8'h01};
    int         eres  [3] = '{2, 2, 0};
    logic       ebusy [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, beats[i], (i == 2), 1'b0);
      checks++;
      if (int'(b_res) !== eres[i] || b_busy !== ebusy[i] || b_done !== (i == 2)) begin
        errors++;
        $display("FAIL frame_beat[%0d]: got res=%0d busy=%0b done=%0b want %0d %0b %0b",
                 i, b_res, b_busy, b_done, eres[i], ebusy[i], (i == 2));
      end
    end
    checks++;
    if (b_fm !== 1'b1 || b_fo !== 16'd12) begin
      errors++;
      $display("FAIL frame_result: got fm=%0b fo=%0d want 1 12", b_fm, b_fo);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (b_done !== 1'b0) begin
      errors++;
      $display("FAIL frame_done_pulse: got %0b want 0", b_done);
    end
  endtask

  task automatic test_gaps();
    drive(1'b1, 8'h0F, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 8'hFF, 1'b1, 1'b0);
      checks++;
      if (b_res !== 2'd1 || b_busy !== 1'b1 || b_done !== 1'b0) begin
        errors++;
        $display("FAIL gap_hold[%0d]: got res=%0d busy=%0b done=%0b want 1 1 0", i, b_res, b_busy, b_done);
      end
    end
    drive(1'b1, 8'h03, 1'b1, 1'b0);
    checks++;
    if (b_done !== 1'b1 || b_fo !== 16'd6 || b_fm !== 1'b1) begin
      errors++;
      $display("FAIL gap_close: got done=%0b fo=%0d fm=%0b want 1 6 1", b_done, b_fo, b_fm);
    end
  endtask

  task automatic test_clear();
    drive(1'b1, 8'h01, 1'b0, 1'b0);
    drive(1'b1, 8'hFF, 1'b1, 1'b1);
    checks++;
    if (b_res !== 2'd0 || b_busy !== 1'b0 || b_done !== 1'b0 || b_fo !== 16'd6) begin
      errors++;
      $display("FAIL clear: got res=%0d busy=%0b done=%0b fo=%0d want 0 0 0 6", b_res, b_busy, b_done, b_fo);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 8'h03, 1'b1, 1'b0);
    checks++;
    if (b_done !== 1'b1 || b_fo !== 16'd2 || b_busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: got done=%0b fo=%0d busy=%0b want 1 2 0", b_done, b_fo, b_busy);
    end
    drive(1'b1, 8'h01, 1'b0, 1'b0);
    checks++;
    if (b_done !== 1'b0 || b_res !== 2'd1 || b_busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: got done=%0b res=%0d busy=%0b want 0 1 1", b_done, b_res, b_busy);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_saturate_and_reset();
    drive(1'b1, 8'hFF, 1'b0, 1'b0);
    drive(1'b1, 8'hFF, 1'b0, 1'b0);
    drive(1'b1, 8'hFF, 1'b1, 1'b0);
    checks++;
    if (c_fo !== 4'd15 || c_done !== 1'b1 || c_fm !== 1'b0) begin
      errors++;
      $display("FAIL saturate: got fo=%0d done=%0b fm=%0b want 15 1 0", c_fo, c_done, c_fm);
    end
    drive(1'b1, 8'hFF, 1'b0, 1'b0);
    checks++;
    if (c_res !== 3'd3 || c_busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got res=%0d busy=%0b want 3 1", c_res, c_busy);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (c_res !== 3'd0 || c_busy !== 1'b0 || c_fo !== 4'd0 || c_done !== 1'b0 || c_match !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got res=%0d busy=%0b fo=%0d done=%0b match=%0b want 0 0 0 0 0",
               c_res, c_busy, c_fo, c_done, c_match);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int wid [3] = '{1, 8, 8};
    int md  [3] = '{2, 3, 5};
    int tg  [3] = '{1, 0, 2};
    int mx  [3] = '{65535, 65535, 15};
    int cnt [3];
    int bsy [3];
    int fdn [3];
    int fmt [3];
    int fon [3];
    for (int i = 0; i < 3; i++) begin
      cnt[i] = 0; bsy[i] = 0; fdn[i] = 0; fmt[i] = 0; fon[i] = 0;
    end
    for (int n = 0; n < 400; n++) begin
      logic       v, l, c;
      logic [7:0] d;
      v = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 4) == 0);
      c = ($urandom_range(0, 24) == 0);
      d = 8'($urandom);
      drive(v, d, l, c);
      for (int i = 0; i < 3; i++) begin
        int p, r, m, b, fd, fm, fo;
        p = (wid[i] == 1) ? int'(d[0]) : $countones(d);
        if (c) begin
          cnt[i] = 0; bsy[i] = 0; fdn[i] = 0;
        end else if (v) begin
          cnt[i] += p;
          if (l) begin
            fdn[i] = 1;
            fmt[i] = ((cnt[i] % md[i]) == tg[i]) ? 1 : 0;
            fon[i] = (cnt[i] > mx[i]) ? mx[i] : cnt[i];
            cnt[i] = 0; bsy[i] = 0;
          end else begin
            fdn[i] = 0; bsy[i] = 1;
          end
        end else begin
          fdn[i] = 0;
        end
        r  = (i == 0) ? int'(a_res)   : (i == 1) ? int'(b_res)   : int'(c_res);
        m  = (i == 0) ? int'(a_match) : (i == 1) ? int'(b_match) : int'(c_match);
        b  = (i == 0) ? int'(a_busy)  : (i == 1) ? int'(b_busy)  : int'(c_busy);
        fd = (i == 0) ? int'(a_done)  : (i == 1) ? int'(b_done)  : int'(c_done);
        fm = (i == 0) ? int'(a_fm)    : (i == 1) ? int'(b_fm)    : int'(c_fm);
        fo = (i == 0) ? int'(a_fo)    : (i == 1) ? int'(b_fo)    : int'(c_fo);
        checks++;
        if (r !== (cnt[i] % md[i]) || m !== (((cnt[i] % md[i]) == tg[i]) ? 1 : 0) ||
            b !== bsy[i] || fd !== fdn[i] || fm !== fmt[i] || fo !== fon[i]) begin
          errors++;
          $display("FAIL random[%0d] dut%0d: got res=%0d match=%0d busy=%0d done=%0d fm=%0d fo=%0d want %0d %0d %0d %0d %0d %0d",
                   n, i, r, m, b, fd, fm, fo, cnt[i] % md[i], ((cnt[i] % md[i]) == tg[i]) ? 1 : 0,
                   bsy[i], fdn[i], fmt[i], fon[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_legacy();
    test_frame();
    test_gaps();
    test_clear();
    test_back_to_back();
    test_saturate_and_reset();
    test_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
